// File: rtl/queue_pkg.sv
// Shared types and widths for the queue occupancy counter and its beam detectors.
package queue_pkg;

  localparam int P_W       = 3;
  localparam int T_W       = 2;
  localparam int P_MAX_DEF = 7;

  typedef enum logic {
    IDLE    = 1'b0,
    BLOCKED = 1'b1
  } sens_state_t;

endpackage

// File: rtl/queue_counter_if.sv
// Sensor inputs, occupancy/status outputs and detector state visibility for queue_counter.
interface queue_counter_if;
  import queue_pkg::*;

  logic             sensEntry;
  logic             sensExit;
  logic             clrErr;
  logic [P_W-1:0]   pCount;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;
  logic             upd;
  sens_state_t      st_entry;
  logic             ev_entry;
  sens_state_t      st_exit;
  logic             ev_exit;

  // Level/strobe bus, no handshake: sensors are free-running levels, clrErr is a
  // one-cycle pulse, upd/ev_* are one-cycle strobes, everything else is a level.
  modport master (
    output sensEntry, sensExit, clrErr,
    input  pCount, full, empty, ovf, unf, upd, st_entry, ev_entry, st_exit, ev_exit
  );

  modport slave (
    input  sensEntry, sensExit, clrErr,
    output pCount, full, empty, ovf, unf, upd, st_entry, ev_entry, st_exit, ev_exit
  );
endinterface

// File: rtl/queue_counter_beam_detect.sv
// Beam detector: 2-flop synchronizer, optional debounce (QUEUE_DEBOUNCE_EN), IDLE/BLOCKED FSM.
// Emits a one-cycle ev when a blocked beam clears, i.e. a person has fully passed.
module beam_detect
  import queue_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sens,
  output logic        ev,
  output sens_state_t state
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 15) begin : g_bad_deb
    $error("beam_detect: DEB_CYCLES out of range 1..15");
  end

  logic [1:0] sync;
  logic       filt;

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], sens};
  end

`ifdef QUEUE_DEBOUNCE_EN
  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  logic [3:0] deb_cnt;

  // Level is accepted only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt    <= 1'b0;
      deb_cnt <= 4'd0;
    end else if (sync[1] == filt) begin
      deb_cnt <= 4'd0;
    end else if (deb_cnt == DEB_LAST) begin
      filt    <= sync[1];
      deb_cnt <= 4'd0;
    end else begin
      deb_cnt <= deb_cnt + 4'd1;
    end
  end
`else
  assign filt = sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ev    <= 1'b0;
    end else begin
      ev <= 1'b0;
      case (state)
        IDLE:    if (filt) state <= BLOCKED;
        BLOCKED: if (!filt) begin
          state <= IDLE;
          ev    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/queue_counter.sv
// Queue occupancy counter fed by entrance/service beam detectors; saturating, sticky errors.
// Optional sensor debounce is enabled with `define QUEUE_DEBOUNCE_EN.
module queue_counter
  import queue_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int P_MAX      = P_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  queue_counter_if.slave  bus
);

  localparam logic [P_W-1:0] CMAX = P_W'(P_MAX);

  logic           ev_in, ev_out;
  logic [P_W-1:0] cnt_nxt;
  logic           upd_nxt, ovf_set, unf_set;

  beam_detect #(.DEB_CYCLES(DEB_CYCLES)) u_entry (
    .clk(clk), .rst(rst), .sens(bus.sensEntry), .ev(ev_in), .state(bus.st_entry)
  );

  beam_detect #(.DEB_CYCLES(DEB_CYCLES)) u_exit (
    .clk(clk), .rst(rst), .sens(bus.sensExit), .ev(ev_out), .state(bus.st_exit)
  );

  assign bus.ev_entry = ev_in;
  assign bus.ev_exit  = ev_out;

  // Simultaneous entry and exit cancel: no change, no strobe, no error.
  always_comb begin
    cnt_nxt = bus.pCount;
    upd_nxt = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ev_in && !ev_out) begin
      if (bus.pCount < CMAX) begin
        cnt_nxt = bus.pCount + 1'b1;
        upd_nxt = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (ev_out && !ev_in) begin
      if (bus.pCount != '0) begin
        cnt_nxt = bus.pCount - 1'b1;
        upd_nxt = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  // full/empty come from the same next value so they never lag pCount.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pCount <= '0;
      bus.full   <= 1'b0;
      bus.empty  <= 1'b1;
      bus.upd    <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.unf    <= 1'b0;
    end else begin
      bus.pCount <= cnt_nxt;
      bus.full   <= (cnt_nxt == CMAX);
      bus.empty  <= (cnt_nxt == '0);
      bus.upd    <= upd_nxt;
      bus.ovf    <= ovf_set | (bus.ovf & ~bus.clrErr);
      bus.unf    <= unf_set | (bus.unf & ~bus.clrErr);
    end
  end

endmodule

// File: tb/tb_queue_counter.sv
// Directed plus randomized bench for queue_counter against a people-count model.
module tb_queue_counter;
  import queue_pkg::*;

  localparam int DEB   = 4;
  localparam int PMAX  = 7;
`ifdef QUEUE_DEBOUNCE_EN
  localparam int EXTRA = DEB;
`else
  localparam int EXTRA = 0;
`endif
  localparam int HOLD   = 6;
  localparam int SETTLE = 8 + EXTRA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  queue_counter_if bus ();

  queue_counter #(.DEB_CYCLES(DEB), .P_MAX(PMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;

  // reference model: people count with saturation and sticky flags
  int m_cnt = 0;
  int m_upd = 0;
  bit m_ovf = 0;
  bit m_unf = 0;

  always @(negedge clk) begin
    if (bus.upd === 1'b1) upd_seen++;
    if (!rst) begin
      checks++;
      assert (bus.full === (bus.pCount == 3'(PMAX)) && bus.empty === (bus.pCount == 3'd0))
      else begin
        errors++;
        $error("FAIL flags_consistent observed=full%0b/empty%0b pCount=%0d", bus.full, bus.empty, bus.pCount);
      end
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_ev(bit e, bit x);
    if (e && !x) begin
      if (m_cnt < PMAX) begin m_cnt++; m_upd++; end
      else m_ovf = 1;
    end else if (x && !e) begin
      if (m_cnt > 0) begin m_cnt--; m_upd++; end
      else m_unf = 1;
    end
  endtask

  task automatic pass(bit e, bit x);
    @(negedge clk);
    bus.sensEntry = e;
    bus.sensExit  = x;
    tick(HOLD);
    bus.sensEntry = 0;
    bus.sensExit  = 0;
    tick(SETTLE);
    model_ev(e, x);
  endtask

  task automatic clr_err();
    @(negedge clk);
    bus.clrErr = 1;
    @(negedge clk);
    bus.clrErr = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic check_model(string tag);
    check({tag, "_cnt"}, 32'(bus.pCount), 32'(m_cnt));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
    check({tag, "_unf"}, 32'(bus.unf), 32'(m_unf));
    check({tag, "_upd"}, 32'(upd_seen), 32'(m_upd));
  endtask

  initial begin
    int base;
    int kind;
    bus.sensEntry = 0;
    bus.sensExit  = 0;
    bus.clrErr    = 0;
    tick(3);
    check("rst_cnt",   32'(bus.pCount), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full",  32'(bus.full), 0);
    check("rst_ovf",   32'(bus.ovf), 0);
    check("rst_unf",   32'(bus.unf), 0);
    check("rst_upd",   32'(bus.upd), 0);
    check("rst_st_in", 32'(bus.st_entry), 32'(IDLE));
    check("rst_st_out",32'(bus.st_exit), 32'(IDLE));
    rst = 0;
    tick(2);

    for (int i = 1; i <= 3; i++) begin
      pass(1, 0);
      check("entry_cnt", 32'(bus.pCount), 32'(i));
      check("entry_empty", 32'(bus.empty), 0);
    end
    check("entry_upd3", 32'(upd_seen), 3);

    for (int i = 0; i < 5; i++) pass(1, 0);
    check("sat_cnt", 32'(bus.pCount), 7);
    check("sat_full", 32'(bus.full), 1);
    check("sat_ovf", 32'(bus.ovf), 1);
    check_model("sat");
    clr_err();
    check("clr_ovf", 32'(bus.ovf), 0);
    check("clr_cnt", 32'(bus.pCount), 7);

    // overflow and clrErr on the same edge: the set wins
    @(negedge clk);
    bus.sensEntry = 1;
    tick(HOLD);
    bus.sensEntry = 0;
    repeat (3 + EXTRA) @(posedge clk);
    @(negedge clk);
    bus.clrErr = 1;
    @(negedge clk);
    bus.clrErr = 0;
    tick(SETTLE);
    model_ev(1, 0);
    check("setwin_ovf", 32'(bus.ovf), 1);
    check_model("setwin");
    clr_err();

    for (int i = 0; i < 7; i++) pass(0, 1);
    check_model("drain");
    pass(0, 1);
    check("unf_cnt", 32'(bus.pCount), 0);
    check("unf_flag", 32'(bus.unf), 1);
    check_model("unf");
    clr_err();

    pass(1, 1);
    check_model("both_empty");
    for (int i = 0; i < 4; i++) pass(1, 0);
    base = upd_seen;
    pass(1, 1);
    check("both_cnt", 32'(bus.pCount), 4);
    check("both_noupd", 32'(upd_seen - base), 0);
    check_model("both4");

    // latency: release before edge N, count changes after edge N+3 (+DEB)
    @(negedge clk);
    bus.sensEntry = 1;
    tick(HOLD);
    bus.sensEntry = 0;
    repeat (3 + EXTRA) @(posedge clk);
    #1;
    check("lat_before_cnt", 32'(bus.pCount), 4);
    check("lat_before_upd", 32'(bus.upd), 0);
    @(posedge clk);
    #1;
    check("lat_at_cnt", 32'(bus.pCount), 5);
    check("lat_at_upd", 32'(bus.upd), 1);
    tick(SETTLE);
    model_ev(1, 0);
    check_model("lat");

`ifdef QUEUE_DEBOUNCE_EN
    @(negedge clk);
    bus.sensEntry = 1;
    tick(2);
    bus.sensEntry = 0;
    tick(SETTLE);
    check("glitch_cnt", 32'(bus.pCount), 5);
    check_model("glitch");
`endif

    // reset while the entrance beam is held
    @(negedge clk);
    bus.sensEntry = 1;
    tick(HOLD);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_cnt", 32'(bus.pCount), 0);
    check("midrst_empty", 32'(bus.empty), 1);
    tick(8 + EXTRA);
    check("midrst_held_cnt", 32'(bus.pCount), 0);
    check("midrst_held_st", 32'(bus.st_entry), 32'(BLOCKED));
    bus.sensEntry = 0;
    tick(SETTLE);
    m_cnt = 1; m_ovf = 0; m_unf = 0; m_upd++;
    check("midrst_release", 32'(bus.pCount), 1);
    check_model("midrst");

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0, 1:    pass(1, 0);
        2:       pass(0, 1);
        3:       pass(1, 1);
        default: clr_err();
      endcase
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
